// File: rtl/uart_tx.sv
// uart_tx: UART transmitter that serialises bytes as 8N1 frames on tx_pin_o.
// A one-entry holding register accepts the next byte while the current frame
// shifts out, so back-to-back frames leave no idle gap between them.
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit (8E1 frames).
//
// state  | meaning
// -------+-----------------------------------------------
// IDLE   | line high, waiting for the holding register
// START  | driving the start bit (low)
// DATA   | shifting data bits out, LSB first
// PARITY | driving the even-parity bit (parity build only)
// STOP   | driving the stop bit (high)
module uart_tx #(
   parameter int UART_DATA_SIZE     = 8,
   parameter int UART_BAUD_DIV_SIZE = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [UART_BAUD_DIV_SIZE-1:0] baud_div_i,
   input  logic [UART_DATA_SIZE-1:0]     tx_data_i,
   input  logic                          tx_valid_i,
   output logic                          tx_ready_o,
   output logic                          tx_pin_o,
   output logic                          tx_busy_o,
   output logic                          tx_done_o
);

   localparam int CNT_W = (UART_DATA_SIZE > 1) ? $clog2(UART_DATA_SIZE) : 1;
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(UART_DATA_SIZE - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
   } state_t;

   state_t                        state_q, state_d;
   logic                          pin_q, pin_d;
   logic                          done_q, done_d;
   logic                          hold_full_q, hold_full_d;
   logic [UART_DATA_SIZE-1:0]     hold_q, hold_d;
   logic [UART_DATA_SIZE-1:0]     shift_q, shift_d;
   logic [CNT_W-1:0]              bit_cnt_q, bit_cnt_d;
   logic [UART_BAUD_DIV_SIZE-1:0] baud_cnt_q, baud_cnt_d;
`ifdef UART_TX_PARITY_EN
   logic                          parity_q, parity_d;
`endif

   logic                          bit_end;
   logic                          load_frame;
   logic                          bit_start;
   logic [UART_BAUD_DIV_SIZE-1:0] div_eff;

   // Divisors below 2 cannot produce a sensible bit; clamp them to 2.
   assign div_eff = (baud_div_i < UART_BAUD_DIV_SIZE'(2)) ? UART_BAUD_DIV_SIZE'(2) : baud_div_i;
   assign bit_end = (baud_cnt_q == UART_BAUD_DIV_SIZE'(1));

   // State and datapath registers; reset drops the line to idle and discards any queued byte.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         pin_q       <= 1'b1;
         done_q      <= 1'b0;
         hold_full_q <= 1'b0;
         hold_q      <= '0;
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         baud_cnt_q  <= '0;
`ifdef UART_TX_PARITY_EN
         parity_q    <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         pin_q       <= pin_d;
         done_q      <= done_d;
         hold_full_q <= hold_full_d;
         hold_q      <= hold_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         baud_cnt_q  <= baud_cnt_d;
`ifdef UART_TX_PARITY_EN
         parity_q    <= parity_d;
`endif
      end
   end

   // Next-state logic; a queued byte at the end of STOP chains straight into START.
   always_comb begin
      state_d    = state_q;
      load_frame = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (hold_full_q) begin
               state_d    = S_START;
               load_frame = 1'b1;
            end
         end
         S_START:  if (bit_end) state_d = S_DATA;
         S_DATA: begin
            if (bit_end && (bit_cnt_q == '0)) begin
`ifdef UART_TX_PARITY_EN
               state_d = S_PARITY;
`else
               state_d = S_STOP;
`endif
            end
         end
         S_PARITY: if (bit_end) state_d = S_STOP;
         S_STOP: begin
            if (bit_end) begin
               if (hold_full_q) begin
                  state_d    = S_START;
                  load_frame = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default:  state_d = S_IDLE;
      endcase
      bit_start = (state_d != state_q) || ((state_q == S_DATA) && bit_end);
   end

   // Output and datapath next values: handshake, shifter, bit/baud counters, registered pin.
   always_comb begin
      pin_d       = pin_q;
      done_d      = 1'b0;
      hold_full_d = hold_full_q;
      hold_d      = hold_q;
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
`ifdef UART_TX_PARITY_EN
      parity_d    = parity_q;
`endif

      // Accept and drain never coincide: accept needs the holding register empty, drain needs it full.
      if (tx_valid_i && !hold_full_q) begin
         hold_d      = tx_data_i;
         hold_full_d = 1'b1;
      end
      if (load_frame) begin
         shift_d     = hold_q;
         hold_full_d = 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_d    = ^hold_q;
`endif
      end

      if (state_d == S_IDLE)
         baud_cnt_d = '0;
      else if (bit_start)
         baud_cnt_d = div_eff;
      else
         baud_cnt_d = baud_cnt_q - UART_BAUD_DIV_SIZE'(1);

      case (state_q)
         S_IDLE:   if (load_frame) pin_d = 1'b0;
         S_START: begin
            if (bit_end) begin
               pin_d     = shift_q[0];
               bit_cnt_d = BIT_LAST;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               if (bit_cnt_q != '0) begin
                  shift_d   = {1'b0, shift_q[UART_DATA_SIZE-1:1]};
                  pin_d     = shift_q[1];
                  bit_cnt_d = bit_cnt_q - 1'b1;
               end else begin
`ifdef UART_TX_PARITY_EN
                  pin_d = parity_q;
`else
                  pin_d = 1'b1;
`endif
               end
            end
         end
         S_PARITY: if (bit_end) pin_d = 1'b1;
         S_STOP: begin
            if (bit_end) begin
               done_d = 1'b1;
               pin_d  = !load_frame;
            end
         end
         default:  pin_d = 1'b1;
      endcase
   end

   assign tx_ready_o = !hold_full_q;
   assign tx_pin_o   = pin_q;
   assign tx_busy_o  = (state_q != S_IDLE);
   assign tx_done_o  = done_q;

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter that serialises bytes onto the TX pin using the 8N1 frame format: one start bit, 8 data bits LSB first, and one stop bit.
- Bit timing comes from the same baud divisor value driven to the UART receiver. One bit period is exactly `baud_div_i` clk cycles.
- Sits in the UART peripheral between the register interface (TX data write) and the off-chip `tx_pin_o`.
- A one-entry holding register lets software queue the next byte while the current frame is shifting, so back-to-back frames have no gap.

Parameters:
- UART_DATA_SIZE, 8, data bits per frame.
- UART_BAUD_DIV_SIZE, 16, width of the baud divisor.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous, active-low reset.
- baud_div_i  input  UART_BAUD_DIV_SIZE  clk cycles per bit; legal values are ≥2.
- tx_data_i  input  UART_DATA_SIZE  byte to send.
- tx_valid_i  input  1  tx_data_i is valid.
- tx_ready_o  output  1  holding register is empty and can accept a byte.
- tx_pin_o  output  1  serial line, idles high.
- tx_busy_o  output  1  a frame is in progress (state is not IDLE).
- tx_done_o  output  1  one-cycle pulse at the end of each stop bit.

Behaviour:
- Reset (asynchronous):
  - state=IDLE, tx_pin_o=1, tx_ready_o=1, tx_busy_o=0, tx_done_o=0.
  - Holding register empty; shifter, bit counter and baud counter all 0.
- Handshake and holding register:
  - A transfer occurs on a clk edge where tx_valid_i && tx_ready_o; the holding register captures tx_data_i and is marked full.
  - tx_ready_o = !hold_full, driven from a register with no combinational path from tx_valid_i.
  - tx_valid_i while tx_ready_o=0 is ignored; the byte is not captured.
- Baud counter:
  - On entry to every bit it is loaded with baud_div_i, then decrements each cycle.
  - The bit ends on the cycle where the count is 1, so each bit lasts exactly baud_div_i cycles.
  - baud_div_i is sampled only at bit start; a change mid-bit takes effect from the next bit.
  - Values 0 and 1 are treated as 2.
- tx_pin_o is registered and updated on the same edge as the state.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx_pin_o=1. If hold_full, go to START on the next edge: shifter<=hold, hold_full<=0, tx_pin_o<=0, load baud counter.
  - Latency: tx_pin_o falls on the first edge after the handshake edge.
  - START: at bit end, go to DATA with tx_pin_o<=shifter[0] and bit_count<=UART_DATA_SIZE-1.
  - DATA: at each bit end, if bit_count≠0, shift right, drive the next LSB and decrement bit_count; else go to STOP with tx_pin_o<=1.
  - STOP: at bit end, pulse tx_done_o for one cycle. If hold_full, go directly to START with the same load actions as IDLE→START (zero idle cycles); else go to IDLE.
- Frame length is 10×baud_div_i cycles.
- tx_ready_o rises the cycle after the holding register drains to the shifter. A handshake in the same cycle as the drain is impossible because ready is 0 then.
- Reset mid-frame: tx_pin_o returns to 1 immediately and the queued byte is discarded. No partial frame resumes after reset.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - It drives even parity (XOR of all data bits) for one bit period.
  - Frame is 11×baud_div_i cycles.
- Undefined:
  - No PARITY state; 8N1 only, as described above.
- The port list is identical in both builds.

Test Plan:
- baud_div_i=4, send 0xA5 from IDLE:
  - Pin low at the edge after the handshake.
  - Sequence 0,1,0,1,0,0,1,0,1,1, each level held for 4 cycles.
  - tx_done_o pulses once, 40 cycles after pin fall.
- baud_div_i=4, send 0x55 then 0xAA with tx_valid_i held high:
  - 0xAA is accepted about 1 cycle after the 0x55 frame starts; tx_ready_o then stays 0 until the 0xAA frame starts.
  - No idle cycle between the frames: second start bit begins on the cycle after the first stop bit ends.
  - Two tx_done_o pulses, 40 cycles apart.
- baud_div_i=2 and baud_div_i=0:
  - Both produce 2-cycle bits; frame is 20 cycles.
- Assert rst_n low during bit 3 of 0xFF with a byte queued:
  - tx_pin_o=1 immediately; tx_ready_o=1, tx_busy_o=0.
  - No further frame after reset is released.
- Loopback into the UART receiver at baud_div_i=16, bytes 0x00, 0xFF, 0x3C:
  - Receiver reports valid with matching data for each byte and frame_err=0.
- UART_TX_PARITY_EN, baud_div_i=4, send 0x07:
  - Parity bit=1 in the slot after bit 7, then stop bit.
  - Frame is 44 cycles.
